memory_stage: RTL and testbench

Memory stage of the five-stage Y86-64 pipeline. Holds the M pipeline register, which captures execute-stage results each cycle. It also owns the byte-addressed data memory, performing one 64-bit little-endian read or write per instruction. It sits between execute and the W pipeline register, and supplies the memory-stage forwarding sources and `m_stat` back to execute and the pipeline controller.

---
 rtl/memory_stage.sv | 177 +++++++++++++++++
 tb/tb_memory_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: memory stage of a five-stage Y86-64 pipeline.
// Holds the M pipeline register and a byte-addressed data memory with one
// 64-bit little-endian read or write per instruction.
// Optional build macro: MEM_ALIGN_CHECK_EN -- when defined, any access whose
// address is not a multiple of 8 is treated as a bad address.
module memory_stage #(
   parameter int MEM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        M_stall,
   input  logic        M_bubble,
   input  logic [2:0]  e_stat,
   input  logic [3:0]  e_icode,
   input  logic        e_Cnd,
   input  logic [63:0] e_valE,
   input  logic [63:0] e_valA,
   input  logic [3:0]  e_dstE,
   input  logic [3:0]  e_dstM,
   output logic [2:0]  m_stat,
   output logic [3:0]  m_icode,
   output logic        m_Cnd,
   output logic [63:0] m_valE,
   output logic [63:0] m_valM,
   output logic [3:0]  m_dstE,
   output logic [3:0]  m_dstM
);

   localparam int          ADDR_W  = $clog2(MEM_BYTES);
   // Highest start address whose 8-byte window still fits inside memory.
   localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);

   typedef enum logic [3:0] {
      I_HALT   = 4'd0,
      I_NOP    = 4'd1,
      I_RRMOVQ = 4'd2,
      I_IRMOVQ = 4'd3,
      I_RMMOVQ = 4'd4,
      I_MRMOVQ = 4'd5,
      I_OPQ    = 4'd6,
      I_JXX    = 4'd7,
      I_CALL   = 4'd8,
      I_RET    = 4'd9,
      I_PUSHQ  = 4'd10,
      I_POPQ   = 4'd11
   } icode_e;

   typedef enum logic [2:0] {
      S_AOK = 3'd1,
      S_HLT = 3'd2,
      S_ADR = 3'd3,
      S_INS = 3'd4
   } stat_e;

   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic        cnd;
      logic [63:0] val_e;
      logic [63:0] val_a;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
   } m_reg_t;

   localparam m_reg_t BUBBLE = '{
      stat:  S_AOK,
      icode: I_NOP,
      cnd:   1'b0,
      val_e: 64'd0,
      val_a: 64'd0,
      dst_e: 4'hF,
      dst_m: 4'hF
   };

   m_reg_t            r_m;
   logic [7:0]        r_mem [MEM_BYTES];

   logic [63:0]       w_addr;
   logic              w_rd_sel;
   logic              w_wr_sel;
   logic              w_access;
   logic              w_range_bad;
   logic              w_align_bad;
   logic              w_bad;
   logic              w_we;
   logic [ADDR_W-1:0] w_idx;
   logic [63:0]       w_rd_raw;

   // M pipeline register: stall beats bubble beats capture.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m <= BUBBLE;
      end else if (M_stall) begin
         r_m <= r_m;
      end else if (M_bubble) begin
         r_m <= BUBBLE;
      end else begin
         r_m <= '{
            stat:  e_stat,
            icode: e_icode,
            cnd:   e_Cnd,
            val_e: e_valE,
            val_a: e_valA,
            dst_e: e_dstE,
            dst_m: e_dstM
         };
      end
   end

   // Decode the registered icode into access type and effective address.
   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave a value unassigned and infer a latch.
   always_comb begin
      w_addr   = 64'd0;
      w_rd_sel = 1'b0;
      w_wr_sel = 1'b0;
      case (r_m.icode)
         I_RMMOVQ, I_CALL, I_PUSHQ: begin
            w_addr   = r_m.val_e;
            w_wr_sel = 1'b1;
         end
         I_MRMOVQ: begin
            w_addr   = r_m.val_e;
            w_rd_sel = 1'b1;
         end
         I_RET, I_POPQ: begin
            w_addr   = r_m.val_a;
            w_rd_sel = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_access    = w_rd_sel | w_wr_sel;
   // Full 64-bit unsigned compare, so huge addresses never wrap into range.
   assign w_range_bad = (w_addr > LAST_OK);
`ifdef MEM_ALIGN_CHECK_EN
   assign w_align_bad = (w_addr[2:0] != 3'd0);
`else
   assign w_align_bad = 1'b0;
`endif
   assign w_bad       = w_access & (w_range_bad | w_align_bad);
   // Stores only commit for a healthy instruction at a legal address.
   assign w_we        = w_wr_sel & ~w_bad & (r_m.stat == S_AOK);
   assign w_idx       = w_addr[ADDR_W-1:0];

   // Assemble eight consecutive bytes little-endian (byte at addr -> [7:0]).
   always_comb begin
      w_rd_raw = 64'd0;
      for (int i = 0; i < 8; i++) begin
         w_rd_raw[8*i +: 8] = r_mem[w_idx + ADDR_W'(i)];
      end
   end

   // Data memory write port; call supplies its return address through valA.
   // NOTE: the memory array has no reset -- contents survive rst_n and start
   // undefined, which also lets it map onto RAM. Gating with rst_n drops a
   // store that coincides with reset assertion.
   always_ff @(posedge clk) begin
      if (rst_n && w_we) begin
         for (int i = 0; i < 8; i++) begin
            r_mem[w_idx + ADDR_W'(i)] <= r_m.val_a[8*i +: 8];
         end
      end
   end

   assign m_stat  = w_bad ? S_ADR : r_m.stat;
   assign m_valM  = (w_rd_sel && !w_bad) ? w_rd_raw : 64'd0;
   assign m_icode = r_m.icode;
   assign m_Cnd   = r_m.cnd;
   assign m_valE  = r_m.val_e;
   assign m_dstE  = r_m.dst_e;
   assign m_dstM  = r_m.dst_m;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage.
// Expected values are hand-computed; honours MEM_ALIGN_CHECK_EN if defined.
module tb_memory_stage;

   localparam int MEM_BYTES = 4096;

   logic        clk;
   logic        rst_n;
   logic        M_stall;
   logic        M_bubble;
   logic [2:0]  e_stat;
   logic [3:0]  e_icode;
   logic        e_Cnd;
   logic [63:0] e_valE;
   logic [63:0] e_valA;
   logic [3:0]  e_dstE;
   logic [3:0]  e_dstM;
   logic [2:0]  m_stat;
   logic [3:0]  m_icode;
   logic        m_Cnd;
   logic [63:0] m_valE;
   logic [63:0] m_valM;
   logic [3:0]  m_dstE;
   logic [3:0]  m_dstM;

   int checks   = 0;
   int failures = 0;

   memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .M_stall  (M_stall),
      .M_bubble (M_bubble),
      .e_stat   (e_stat),
      .e_icode  (e_icode),
      .e_Cnd    (e_Cnd),
      .e_valE   (e_valE),
      .e_valA   (e_valA),
      .e_dstE   (e_dstE),
      .e_dstM   (e_dstM),
      .m_stat   (m_stat),
      .m_icode  (m_icode),
      .m_Cnd    (m_Cnd),
      .m_valE   (m_valE),
      .m_valM   (m_valM),
      .m_dstE   (m_dstE),
      .m_dstM   (m_dstM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
      end
   endtask

   // Present one execute-stage instruction, then step past the capturing edge.
   task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic cnd,
                        input logic [63:0] ve, input logic [63:0] va,
                        input logic [3:0] de, input logic [3:0] dm);
      e_stat  = st;
      e_icode = ic;
      e_Cnd   = cnd;
      e_valE  = ve;
      e_valA  = va;
      e_dstE  = de;
      e_dstM  = dm;
      @(posedge clk);
      #1;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_stat"},  64'(m_stat),  64'd1);
      check({tag, "_icode"}, 64'(m_icode), 64'd1);
      check({tag, "_cnd"},   64'(m_Cnd),   64'd0);
      check({tag, "_valE"},  m_valE,       64'd0);
      check({tag, "_valM"},  m_valM,       64'd0);
      check({tag, "_dstE"},  64'(m_dstE),  64'hF);
      check({tag, "_dstM"},  64'(m_dstM),  64'hF);
   endtask

   initial begin
      rst_n    = 1'b1;
      M_stall  = 1'b0;
      M_bubble = 1'b0;
      e_stat   = 3'd1;
      e_icode  = 4'd6;
      e_Cnd    = 1'b1;
      e_valE   = 64'h55;
      e_valA   = 64'h66;
      e_dstE   = 4'd2;
      e_dstM   = 4'd3;

      // Reset: asynchronous bubble, held across two edges.
      #3 rst_n = 1'b0;
      #1 check_bubble("rst_async");
      @(posedge clk);
      @(posedge clk);
      #1 check_bubble("rst_held");
      rst_n = 1'b1;

      // Store then load (read-after-write on the very next cycle).
      drive(3'd1, 4'd4, 1'b1, 64'h100, 64'h1122334455667788, 4'hF, 4'hF);
      check("st_stat",  64'(m_stat),  64'd1);
      check("st_icode", 64'(m_icode), 64'd4);
      check("st_cnd",   64'(m_Cnd),   64'd1);
      check("st_valM",  m_valM,       64'd0);
      drive(3'd1, 4'd5, 1'b0, 64'h100, 64'h0, 4'hF, 4'd3);
      check("ld_valM",  m_valM,       64'h1122334455667788);
      check("ld_stat",  64'(m_stat),  64'd1);
      check("ld_dstM",  64'(m_dstM),  64'd3);
      check("mem_0x100", 64'(dut.r_mem[256]), 64'h88);

      // Fill 0x108..0x10F, then an unaligned load at 0x103.
      drive(3'd1, 4'd4, 1'b0, 64'h108, 64'h0807060504030201, 4'hF, 4'hF);
      drive(3'd1, 4'd5, 1'b0, 64'h103, 64'h0, 4'hF, 4'd1);
`ifdef MEM_ALIGN_CHECK_EN
      check("unal_stat", 64'(m_stat), 64'd3);
      check("unal_valM", m_valM,      64'd0);
`else
      check("unal_stat", 64'(m_stat), 64'd1);
      check("unal_valM", m_valM,      64'h0302011122334455);
`endif

      // Stack pair: pushq then popq; valE passes through.
      drive(3'd1, 4'd10, 1'b0, 64'h1F8, 64'hDEAD, 4'd4, 4'hF);
      check("push_stat", 64'(m_stat), 64'd1);
      drive(3'd1, 4'd11, 1'b0, 64'h200, 64'h1F8, 4'd4, 4'd5);
      check("pop_valM", m_valM,      64'hDEAD);
      check("pop_valE", m_valE,      64'h200);
      check("pop_dstE", 64'(m_dstE), 64'd4);
      check("pop_dstM", 64'(m_dstM), 64'd5);

      // Last legal address, then an out-of-range store that must not write.
      drive(3'd1, 4'd4, 1'b0, 64'(MEM_BYTES - 8), 64'hAAAABBBBCCCCDDDD, 4'hF, 4'hF);
      check("edge_st_stat", 64'(m_stat), 64'd1);
      drive(3'd1, 4'd4, 1'b0, 64'(MEM_BYTES - 4), 64'h1234, 4'hF, 4'hF);
      check("bad_st_stat", 64'(m_stat), 64'd3);
      check("bad_st_valM", m_valM,      64'd0);
      drive(3'd1, 4'd5, 1'b0, 64'(MEM_BYTES - 8), 64'h0, 4'hF, 4'd1);
      check("bad_rd_back", m_valM,      64'hAAAABBBBCCCCDDDD);
      check("bad_rd_stat", 64'(m_stat), 64'd1);

      // Range boundary: first illegal start address and a wrap-prone huge one.
      drive(3'd1, 4'd5, 1'b0, 64'(MEM_BYTES - 7), 64'h0, 4'hF, 4'd1);
      check("oob1_stat", 64'(m_stat), 64'd3);
      check("oob1_valM", m_valM,      64'd0);
      drive(3'd1, 4'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 4'hF, 4'd1);
      check("huge_stat", 64'(m_stat), 64'd3);
      check("huge_valM", m_valM,      64'd0);

      // Non-AOK stat suppresses the write and passes its stat through.
      drive(3'd2, 4'd4, 1'b0, 64'(MEM_BYTES - 8), 64'h5555, 4'hF, 4'hF);
      check("hlt_stat", 64'(m_stat), 64'd2);
      drive(3'd1, 4'd5, 1'b0, 64'(MEM_BYTES - 8), 64'h0, 4'hF, 4'd1);
      check("hlt_no_wr", m_valM, 64'hAAAABBBBCCCCDDDD);

      // call writes valA at valE; ret reads it back via valA.
      drive(3'd1, 4'd8, 1'b0, 64'h1F0, 64'h777, 4'd4, 4'hF);
      drive(3'd1, 4'd9, 1'b0, 64'h1F8, 64'h1F0, 4'd4, 4'hF);
      check("ret_valM", m_valM, 64'h777);

      // Stall holds for two cycles, stall+bubble holds, bubble alone bubbles.
      M_stall = 1'b1;
      drive(3'd1, 4'd6, 1'b1, 64'h99, 64'h0, 4'd2, 4'hF);
      check("stall1_icode", 64'(m_icode), 64'd9);
      check("stall1_valM",  m_valM,       64'h777);
      drive(3'd1, 4'd6, 1'b1, 64'h99, 64'h0, 4'd2, 4'hF);
      check("stall2_icode", 64'(m_icode), 64'd9);
      check("stall2_valE",  m_valE,       64'h1F8);
      M_bubble = 1'b1;
      drive(3'd1, 4'd6, 1'b1, 64'h99, 64'h0, 4'd2, 4'hF);
      check("both_icode", 64'(m_icode), 64'd9);
      check("both_valM",  m_valM,       64'h777);
      M_stall = 1'b0;
      drive(3'd1, 4'd6, 1'b1, 64'h99, 64'h0, 4'd2, 4'hF);
      check_bubble("bubble");
      M_bubble = 1'b0;
      drive(3'd1, 4'd6, 1'b1, 64'h99, 64'h0, 4'd2, 4'hF);
      check("opq_icode", 64'(m_icode), 64'd6);
      check("opq_valE",  m_valE,       64'h99);
      check("opq_dstE",  64'(m_dstE),  64'd2);
      check("opq_cnd",   64'(m_Cnd),   64'd1);
      check("opq_valM",  m_valM,       64'd0);

      // Reset mid-run with a store pending: outputs bubble at once, store lost.
      drive(3'd1, 4'd4, 1'b0, 64'h100, 64'hBAD0BAD0BAD0BAD0, 4'hF, 4'hF);
      #1 rst_n = 1'b0;
      #1 check_bubble("rst_mid");
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(3'd1, 4'd5, 1'b0, 64'h100, 64'h0, 4'hF, 4'd3);
      check("rst_drop_wr", m_valM, 64'h1122334455667788);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
